// File: rtl/data_bus_mmio.sv
// data_bus_mmio: data-side bus slave behind the core's Memory stage.
// It decodes the byte address into two regions: a word-addressed data RAM
// and a 64-byte peripheral page. The page holds GPIO out, synchronized
// GPIO in, and a compare timer with an interrupt.
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   MemRead/MemWrite  core strobes
//   RWAddress         byte address
//   WriteData         store data
//   MemData           combinational read data (the core registers it)
//   gpio_in/gpio_out  external GPIO
//   timer_irq         STAT.MATCH & CTRL.IRQEN
//   bus_err           sticky misaligned/unmapped access flag
module data_bus_mmio #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RAM_BASE   = 32'h1001_0000,
    parameter int                    RAM_WORDS  = 64,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 32'h1002_0000,
    parameter int                    GPIO_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [ADDR_WIDTH-1:0] RWAddress,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] MemData,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic                  timer_irq,
    output logic                  bus_err
);
    localparam int IDX_W = $clog2(RAM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] RAM_BYTES = ADDR_WIDTH'(4 * RAM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] IO_BYTES  = ADDR_WIDTH'(64);

    localparam logic [3:0] R_GPIO_OUT = 4'h0;
    localparam logic [3:0] R_GPIO_IN  = 4'h1;
    localparam logic [3:0] R_CNT      = 4'h2;
    localparam logic [3:0] R_CMP      = 4'h3;
    localparam logic [3:0] R_CTRL     = 4'h4;
    localparam logic [3:0] R_STAT     = 4'h5;

    logic [DATA_WIDTH-1:0] ram [RAM_WORDS];

    logic [GPIO_WIDTH-1:0] gpio_sync1, gpio_sync2;
    logic [DATA_WIDTH-1:0] cnt, cmp, cnt_next;
    logic [2:0]            ctrl;   // {IRQEN, AUTOCLR, EN}
    logic                  stat, stat_next;

    // Subtracting the base means one unsigned compare per region is enough.
    // An address below the base wraps to a large offset, so it misses.
    logic [ADDR_WIDTH-1:0] ram_off, io_off;
    logic                  ram_hit, io_hit, strobe, misaligned, wr_ok, io_wr, err_set;
    logic [IDX_W-1:0]      ram_idx;
    logic [3:0]            io_idx;
    logic [DATA_WIDTH-1:0] io_rdata;
    logic                  timer_hit;

    always_comb begin
        ram_off    = RWAddress - RAM_BASE;
        io_off     = RWAddress - IO_BASE;
        ram_hit    = ram_off < RAM_BYTES;
        io_hit     = io_off < IO_BYTES;
        ram_idx    = ram_off[IDX_W+1:2];
        io_idx     = io_off[5:2];
        strobe     = MemRead | MemWrite;
        misaligned = strobe && (RWAddress[1:0] != 2'b00);
        wr_ok      = MemWrite && (RWAddress[1:0] == 2'b00);
        io_wr      = wr_ok && io_hit;
        err_set    = misaligned || (strobe && !ram_hit && !io_hit);
    end

    // Peripheral read mux. Unused page slots read as zero.
    always_comb begin
        io_rdata = '0;
        case (io_idx)
            R_GPIO_OUT: io_rdata[GPIO_WIDTH-1:0] = gpio_out;
            R_GPIO_IN:  io_rdata[GPIO_WIDTH-1:0] = gpio_sync2;
            R_CNT:      io_rdata = cnt;
            R_CMP:      io_rdata = cmp;
            R_CTRL:     io_rdata[2:0] = ctrl;
            R_STAT:     io_rdata[0] = stat;
            default:    io_rdata = '0;
        endcase
    end

    // Read data reflects the pre-write state, because writes land on the edge.
    // Reset gates the output, since RAM contents are not cleared.
    always_comb begin
        MemData = '0;
        if (rst && MemRead && !misaligned) begin
            if (ram_hit)     MemData = ram[ram_idx];
            else if (io_hit) MemData = io_rdata;
        end
    end

    // Timer next state. A software CNT write overrides the increment.
    // A MATCH set overrides a W1C landing on the same edge.
    always_comb begin
        timer_hit = (cnt == cmp);
        cnt_next  = cnt;
        if (ctrl[0]) cnt_next = (timer_hit && ctrl[1]) ? '0 : cnt + 1'b1;
        if (io_wr && io_idx == R_CNT) cnt_next = WriteData;

        stat_next = stat;
        if (io_wr && io_idx == R_STAT && WriteData[0]) stat_next = 1'b0;
        if (ctrl[0] && timer_hit) stat_next = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpio_out   <= '0;
            gpio_sync1 <= '0;
            gpio_sync2 <= '0;
            cnt        <= '0;
            cmp        <= '0;
            ctrl       <= '0;
            stat       <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            gpio_sync1 <= gpio_in;
            gpio_sync2 <= gpio_sync1;
            cnt        <= cnt_next;
            stat       <= stat_next;
            bus_err    <= bus_err | err_set;
            if (io_wr && io_idx == R_GPIO_OUT) gpio_out <= WriteData[GPIO_WIDTH-1:0];
            if (io_wr && io_idx == R_CMP)      cmp      <= WriteData;
            if (io_wr && io_idx == R_CTRL)     ctrl     <= WriteData[2:0];
        end
    end

    // Data RAM. It has no reset, and its read port is asynchronous.
    always_ff @(posedge clk) begin
        if (wr_ok && ram_hit) ram[ram_idx] <= WriteData;
    end

    assign timer_irq = stat & ctrl[2];
endmodule

// File: tb/tb_data_bus_mmio.sv
module tb_data_bus_mmio;
    localparam logic [31:0] RAMB = 32'h1001_0000;
    localparam logic [31:0] IOB  = 32'h1002_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite;
    logic [31:0] RWAddress, WriteData, MemData;
    logic [7:0]  gpio_in, gpio_out;
    logic        timer_irq, bus_err;

    data_bus_mmio dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .RWAddress(RWAddress), .WriteData(WriteData), .MemData(MemData),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .timer_irq(timer_irq), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the register-visible state
    logic [31:0] m_cnt, m_cmp;
    logic [2:0]  m_ctrl;
    logic        m_stat, m_err;
    logic [7:0]  m_gpio;
    logic [31:0] m_ram [int];
    logic [7:0]  ghist [$];
    logic [7:0]  cur_gin;

    typedef struct {
        logic [31:0] data;
        bit          dvalid;
        logic [7:0]  gpio;
        logic        irq;
        logic        err;
    } exp_t;
    exp_t q [$];

    task automatic model_reset();
        m_cnt = 0; m_cmp = 0; m_ctrl = 0; m_stat = 0; m_err = 0; m_gpio = 0;
        m_ram.delete();
        ghist.delete();
        ghist.push_back(8'h0);
        ghist.push_back(8'h0);
    endtask

    // Apply one bus cycle. The expected outputs for this cycle come from the
    // current model state, and then the model advances over the next edge.
    task automatic cycle(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        bit ram_h, io_h, mis, wok, mset, mclr;
        int ridx, iidx;
        logic [31:0] rv, nc, ncmp;
        logic [2:0]  nctrl;
        logic [7:0]  ngpio;
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; RWAddress = addr; WriteData = wd; gpio_in = cur_gin;
        ghist.push_back(cur_gin);
        while (ghist.size() > 3) void'(ghist.pop_front());
        ram_h = (addr >= RAMB) && (addr < RAMB + 256);
        io_h  = (addr >= IOB) && (addr < IOB + 64);
        mis   = (rd || wr) && (addr[1:0] != 2'b00);
        ridx  = int'((addr - RAMB) >> 2);
        iidx  = int'((addr - IOB) >> 2);
        rv = 0; e.dvalid = 1;
        if (rd && !mis) begin
            if (ram_h) begin
                if (m_ram.exists(ridx)) rv = m_ram[ridx];
                else e.dvalid = 0;
            end else if (io_h) begin
                case (iidx)
                    0: rv = {24'h0, m_gpio};
                    1: rv = {24'h0, ghist[0]};
                    2: rv = m_cnt;
                    3: rv = m_cmp;
                    4: rv = {29'h0, m_ctrl};
                    5: rv = {31'h0, m_stat};
                    default: rv = 0;
                endcase
            end
        end
        e.data = rv; e.gpio = m_gpio; e.irq = m_stat & m_ctrl[2]; e.err = m_err;
        q.push_back(e);

        wok = wr && !mis;
        nc = m_cnt; ncmp = m_cmp; nctrl = m_ctrl; ngpio = m_gpio; mset = 0; mclr = 0;
        if (m_ctrl[0]) begin
            mset = (m_cnt == m_cmp);
            nc = (mset && m_ctrl[1]) ? 32'h0 : m_cnt + 1;
        end
        if (wok && io_h) begin
            case (iidx)
                0: ngpio = wd[7:0];
                2: nc = wd;
                3: ncmp = wd;
                4: nctrl = wd[2:0];
                5: mclr = wd[0];
                default: ;
            endcase
        end
        if (wok && ram_h) m_ram[ridx] = wd;
        if ((rd || wr) && (mis || !(ram_h || io_h))) m_err = 1;
        m_stat = mset ? 1'b1 : (mclr ? 1'b0 : m_stat);
        m_cnt = nc; m_cmp = ncmp; m_ctrl = nctrl; m_gpio = ngpio;
    endtask

    task automatic rd_(input logic [31:0] a);                  cycle(1, 0, a, 32'h0); endtask
    task automatic wr_(input logic [31:0] a, input logic [31:0] d); cycle(0, 1, a, d);  endtask

    // Monitor: pops one expectation per cycle and compares against the DUT
    always @(negedge clk) begin
        if (rst && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.dvalid) chk("MemData", MemData, e.data);
            chk("gpio_out",  {24'h0, gpio_out},  {24'h0, e.gpio});
            chk("timer_irq", {31'h0, timer_irq}, {31'h0, e.irq});
            chk("bus_err",   {31'h0, bus_err},   {31'h0, e.err});
        end
    end

    task automatic release_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        int guard;
        rst = 1'b0; MemRead = 0; MemWrite = 0; RWAddress = 0; WriteData = 0;
        gpio_in = 0; cur_gin = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        MemRead = 1; RWAddress = IOB + 8;
        #1;
        chk("rst_MemData",   MemData, 32'h0);
        chk("rst_gpio_out",  {24'h0, gpio_out}, 32'h0);
        chk("rst_timer_irq", {31'h0, timer_irq}, 32'h0);
        chk("rst_bus_err",   {31'h0, bus_err}, 32'h0);
        MemRead = 0;
        release_reset();

        // RAM access
        wr_(RAMB + 4, 32'hDEAD_BEEF);
        cycle(1, 0, RAMB + 4, 32'h0);
        wr_(RAMB, 32'h1);
        rd_(RAMB);
        cycle(1, 1, RAMB + 4, 32'h1234_5678);    // read shows pre-write value
        rd_(RAMB + 4);
        rd_(RAMB + 252);                          // last word (unwritten: data unchecked)

        // GPIO
        wr_(IOB, 32'h0000_01A5);
        rd_(IOB);
        cur_gin = 8'h3C;
        repeat (4) rd_(IOB + 4);
        wr_(IOB + 4, 32'hFF);                     // ignored
        rd_(IOB + 4);

        // Timer auto-clear
        wr_(IOB + 12, 3);
        wr_(IOB + 16, 7);
        repeat (10) rd_(IOB + 8);
        guard = 0;
        while (!(m_stat && m_cnt != 3) && guard < 20) begin rd_(IOB + 8); guard++; end
        wr_(IOB + 20, 1);                         // W1C away from a match
        rd_(IOB + 20);
        guard = 0;
        while (m_cnt != 3 && guard < 20) begin rd_(IOB + 8); guard++; end
        wr_(IOB + 20, 1);                         // W1C colliding with a match
        rd_(IOB + 20);
        wr_(IOB + 20, 0);                         // writing 0 has no effect
        repeat (2) rd_(IOB + 20);
        rd_(IOB + 24); wr_(IOB + 60, 32'hFFFF_FFFF); rd_(IOB + 60);

        // Wrap and write priority
        wr_(IOB + 16, 0);
        wr_(IOB + 8, 32'hFFFF_FFFE);
        wr_(IOB + 12, 5);
        wr_(IOB + 16, 1);
        repeat (4) rd_(IOB + 8);
        wr_(IOB + 8, 32'h100);
        repeat (2) rd_(IOB + 8);

        // Errors
        rd_(32'h2000_0000);
        rd_(RAMB);
        wr_(RAMB + 2, 32'hFFFF_FFFF);
        rd_(RAMB);

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            logic [31:0] a, d;
            int k;
            k = int'($urandom_range(0, 9));
            if (k < 4)       a = RAMB + ($urandom_range(0, 63) << 2);
            else if (k < 8)  a = IOB + ($urandom_range(0, 15) << 2);
            else if (k == 8) a = $urandom;
            else             a = RAMB + ($urandom_range(0, 63) << 2) + $urandom_range(1, 3);
            d = $urandom;
            if (a == IOB + 8 || a == IOB + 12) d = $urandom_range(0, 24);
            if ($urandom_range(0, 7) == 0) cur_gin = 8'($urandom);
            cycle(1'($urandom), 1'($urandom), a, d);
        end

        // Async reset in the middle of a cycle while counting
        cur_gin = 0;
        wr_(IOB, 32'h5A);
        wr_(IOB + 20, 1);
        wr_(IOB + 12, 2);
        wr_(IOB + 8, 0);
        wr_(IOB + 16, 5);
        repeat (4) rd_(IOB + 8);
        @(negedge clk);
        @(posedge clk); #2;
        MemRead = 1; MemWrite = 0; RWAddress = IOB + 8;
        rst = 1'b0;
        #1;
        chk("async_MemData",   MemData, 32'h0);
        chk("async_gpio_out",  {24'h0, gpio_out}, 32'h0);
        chk("async_timer_irq", {31'h0, timer_irq}, 32'h0);
        chk("async_bus_err",   {31'h0, bus_err}, 32'h0);
        q.delete();
        MemRead = 0; gpio_in = 0;
        @(posedge clk);
        release_reset();
        repeat (3) rd_(IOB + 8);
        rd_(IOB + 16);
        rd_(IOB);

        repeat (2) @(negedge clk);
        chk("queue_drained", q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
